// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants, state codes and helpers for the audio recorder
package audio_pkg;

    localparam int SAMPLE_W            = 16;
    localparam int SRAM_ADDR_W         = 20;
    localparam int SAMPLES_PER_SEC_DEF = 32000;

    typedef logic [2:0] ctl_state_t;
    typedef logic [1:0] wr_state_t;

    // Top-level codes are shared with the system controller and the I2S top_state
    localparam ctl_state_t ST_IDLE  = 3'd0;
    localparam ctl_state_t ST_REC   = 3'd1;
    localparam ctl_state_t ST_PAUSE = 3'd2;
    localparam ctl_state_t ST_FLUSH = 3'd3;
    localparam ctl_state_t ST_DONE  = 3'd4;

    localparam wr_state_t W_IDLE   = 2'd0;
    localparam wr_state_t W_SETUP  = 2'd1;
    localparam wr_state_t W_STROBE = 2'd2;
    localparam wr_state_t W_HOLD   = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_recorder_if.sv
// rtl/audio_recorder_if.sv - sample push stream between recorder control and SRAM writer
interface audio_recorder_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] tdata;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/sram_writer.sv
// rtl/sram_writer.sv - one-entry holding register plus 3-cycle asynchronous SRAM write sequencer
module sram_writer
    import audio_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    audio_recorder_if.slave     push,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    output logic                o_busy,
    output logic                o_done,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic [SAMPLE_W-1:0] o_sram_dq,
    output logic                o_sram_dq_oe,
    output logic                o_sram_we_n,
    output logic                o_sram_ce_n,
    output logic                o_sram_oe_n,
    output logic                o_sram_lb_n,
    output logic                o_sram_ub_n
);

    wr_state_t           state_q, state_d;
    logic                pending_q, pending_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] dq_q, dq_d;
    logic                dq_oe_q, dq_oe_d;
    logic                we_n_q, we_n_d;
    logic                ce_n_q, ce_n_d;
    logic                be_n_q, be_n_d;

    // The holding register frees up in W_HOLD, so a sample arriving then is not an overrun
    assign push.tready = !pending_q || (state_q == W_HOLD);
    assign o_busy      = pending_q || (state_q != W_IDLE);
    assign o_done      = (state_q == W_HOLD);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        addr_d    = addr_q;
        dq_d      = dq_q;
        dq_oe_d   = dq_oe_q;
        we_n_d    = we_n_q;
        ce_n_d    = ce_n_q;
        be_n_d    = be_n_q;
        case (state_q)
            W_IDLE: begin
                if (pending_q) begin
                    state_d = W_SETUP;
                    addr_d  = i_wr_addr;
                    dq_d    = hold_q;
                    dq_oe_d = 1'b1;
                    ce_n_d  = 1'b0;
                    be_n_d  = 1'b0;
                    we_n_d  = 1'b1;
                end
            end
            W_SETUP: begin
                state_d = W_STROBE;
                we_n_d  = 1'b0;
            end
            W_STROBE: begin
                state_d = W_HOLD;
                we_n_d  = 1'b1;
            end
            default: begin
                state_d   = W_IDLE;
                pending_d = 1'b0;
                dq_oe_d   = 1'b0;
                ce_n_d    = 1'b1;
                be_n_d    = 1'b1;
            end
        endcase
        if (push.tvalid && push.tready) begin
            pending_d = 1'b1;
            hold_d    = push.tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= W_IDLE;
            pending_q <= 1'b0;
            hold_q    <= '0;
            addr_q    <= '0;
            dq_q      <= '0;
            dq_oe_q   <= 1'b0;
            we_n_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            be_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            dq_q      <= dq_d;
            dq_oe_q   <= dq_oe_d;
            we_n_q    <= we_n_d;
            ce_n_q    <= ce_n_d;
            be_n_q    <= be_n_d;
        end
    end

    assign o_sram_addr  = addr_q;
    assign o_sram_dq    = dq_q;
    assign o_sram_dq_oe = dq_oe_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = 1'b1;
    assign o_sram_lb_n  = be_n_q;
    assign o_sram_ub_n  = be_n_q;

endmodule

// File: rtl/audio_recorder.sv
// rtl/audio_recorder.sv - record control FSM, SRAM write pointer and elapsed-time counter
module audio_recorder
    import audio_pkg::*;
#(
    parameter int                ADDR_W          = SRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR        = {ADDR_W{1'b1}},
    parameter int                SAMPLES_PER_SEC = SAMPLES_PER_SEC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic [SAMPLE_W-1:0] i_record_data,
    input  logic                i_record_valid,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic [SAMPLE_W-1:0] o_sram_dq,
    output logic                o_sram_dq_oe,
    output logic                o_sram_we_n,
    output logic                o_sram_ce_n,
    output logic                o_sram_oe_n,
    output logic                o_sram_lb_n,
    output logic                o_sram_ub_n,
    output logic                o_busy,
    output logic                o_paused,
    output logic                o_full,
    output logic                o_overrun,
    output logic [ADDR_W-1:0]   o_end_addr,
    output logic [7:0]          o_seconds
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int SUB_W = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;

    ctl_state_t       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] end_q, end_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [7:0]       sec_q, sec_d;
    logic             full_q, full_d;
    logic             ovr_q, ovr_d;

    logic w_busy, w_done, at_max, last_write;

    audio_recorder_if push_if ();

    assign at_max     = (wr_ptr_q == {1'b0, MAX_ADDR});
    assign last_write = w_done && at_max;

    // A sample landing on the final write's hold cycle has nowhere to go
    assign push_if.tdata  = i_record_data;
    assign push_if.tvalid = i_record_valid && (state_q == ST_REC) && !full_q && !last_write;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        end_d    = end_q;
        sub_d    = sub_q;
        sec_d    = sec_q;
        full_d   = full_q;
        ovr_d    = ovr_q;
        if (push_if.tvalid && !push_if.tready) begin
            ovr_d = 1'b1;
        end
        if (w_done) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (at_max) begin
                full_d = 1'b1;
            end
            if (sub_q == SUB_W'(SAMPLES_PER_SEC - 1)) begin
                sub_d = '0;
                sec_d = sat_inc8(sec_q);
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d  = ST_REC;
                    wr_ptr_d = '0;
                    sub_d    = '0;
                    sec_d    = '0;
                    full_d   = 1'b0;
                    ovr_d    = 1'b0;
                end
            end
            ST_REC, ST_PAUSE: begin
                if (i_stop || last_write) begin
                    state_d = ST_FLUSH;
                end else if (i_pause) begin
                    state_d = (state_q == ST_REC) ? ST_PAUSE : ST_REC;
                end
            end
            ST_FLUSH: begin
                if (!w_busy) begin
                    state_d = ST_DONE;
                    end_d   = wr_ptr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            end_q    <= '0;
            sub_q    <= '0;
            sec_q    <= '0;
            full_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            end_q    <= end_d;
            sub_q    <= sub_d;
            sec_q    <= sec_d;
            full_q   <= full_d;
            ovr_q    <= ovr_d;
        end
    end

    sram_writer #(.ADDR_W(ADDR_W)) u_writer (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push_if.slave),
        .i_wr_addr    (wr_ptr_q[ADDR_W-1:0]),
        .o_busy       (w_busy),
        .o_done       (w_done),
        .o_sram_addr  (o_sram_addr),
        .o_sram_dq    (o_sram_dq),
        .o_sram_dq_oe (o_sram_dq_oe),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_ce_n  (o_sram_ce_n),
        .o_sram_oe_n  (o_sram_oe_n),
        .o_sram_lb_n  (o_sram_lb_n),
        .o_sram_ub_n  (o_sram_ub_n)
    );

    assign o_busy     = (state_q == ST_REC) || (state_q == ST_PAUSE) || (state_q == ST_FLUSH);
    assign o_paused   = (state_q == ST_PAUSE);
    assign o_full     = full_q;
    assign o_overrun  = ovr_q;
    assign o_end_addr = end_q[ADDR_W] ? {ADDR_W{1'b1}} : end_q[ADDR_W-1:0];
    assign o_seconds  = sec_q;

endmodule

// File: tb/tb_audio_recorder.sv
// tb/tb_audio_recorder.sv - scoreboard bench for audio_recorder: default, small-memory and fast-second instances
module tb_audio_recorder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, pause = 1'b0, stop = 1'b0;
    int   sel = 0;
    int   n_checks = 0, n_fail = 0;
    int   exp_ptr [3];
    int   lo [3];
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];
    logic [35:0] q2 [$];
    logic [35:0] e_mon;

    audio_recorder_if rec_if ();
    assign rec_if.tready = 1'b1;

    logic [19:0] addr [3];
    logic [15:0] dq [3];
    logic [19:0] end_addr [3];
    logic [7:0]  secs [3];
    logic dq_oe [3], we_n [3], ce_n [3], oe_n [3], lb_n [3], ub_n [3];
    logic busy [3], paused [3], full [3], ovr [3];

    always #5 clk = ~clk;

    audio_recorder u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_start(start && sel == 0), .i_pause(pause && sel == 0), .i_stop(stop && sel == 0),
        .i_record_data(rec_if.tdata), .i_record_valid(rec_if.tvalid && sel == 0),
        .o_sram_addr(addr[0]), .o_sram_dq(dq[0]), .o_sram_dq_oe(dq_oe[0]), .o_sram_we_n(we_n[0]),
        .o_sram_ce_n(ce_n[0]), .o_sram_oe_n(oe_n[0]), .o_sram_lb_n(lb_n[0]), .o_sram_ub_n(ub_n[0]),
        .o_busy(busy[0]), .o_paused(paused[0]), .o_full(full[0]), .o_overrun(ovr[0]),
        .o_end_addr(end_addr[0]), .o_seconds(secs[0])
    );

    audio_recorder #(.MAX_ADDR(20'd7)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_start(start && sel == 1), .i_pause(pause && sel == 1), .i_stop(stop && sel == 1),
        .i_record_data(rec_if.tdata), .i_record_valid(rec_if.tvalid && sel == 1),
        .o_sram_addr(addr[1]), .o_sram_dq(dq[1]), .o_sram_dq_oe(dq_oe[1]), .o_sram_we_n(we_n[1]),
        .o_sram_ce_n(ce_n[1]), .o_sram_oe_n(oe_n[1]), .o_sram_lb_n(lb_n[1]), .o_sram_ub_n(ub_n[1]),
        .o_busy(busy[1]), .o_paused(paused[1]), .o_full(full[1]), .o_overrun(ovr[1]),
        .o_end_addr(end_addr[1]), .o_seconds(secs[1])
    );

    audio_recorder #(.SAMPLES_PER_SEC(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_start(start && sel == 2), .i_pause(pause && sel == 2), .i_stop(stop && sel == 2),
        .i_record_data(rec_if.tdata), .i_record_valid(rec_if.tvalid && sel == 2),
        .o_sram_addr(addr[2]), .o_sram_dq(dq[2]), .o_sram_dq_oe(dq_oe[2]), .o_sram_we_n(we_n[2]),
        .o_sram_ce_n(ce_n[2]), .o_sram_oe_n(oe_n[2]), .o_sram_lb_n(lb_n[2]), .o_sram_ub_n(ub_n[2]),
        .o_busy(busy[2]), .o_paused(paused[2]), .o_full(full[2]), .o_overrun(ovr[2]),
        .o_end_addr(end_addr[2]), .o_seconds(secs[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void sb_push(input int i, input logic [35:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int sb_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [35:0] sb_pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // SRAM-side monitor: every we_n low pulse must match the next expected write and last one cycle
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                lo[i] = 0;
            end else if (!we_n[i]) begin
                lo[i]++;
                if (lo[i] == 1) begin
                    if (sb_size(i) == 0) begin
                        check("wr_unexpected", sb_size(i), 1);
                    end else begin
                        e_mon = sb_pop(i);
                        check("wr_addr", {12'd0, addr[i]}, {12'd0, e_mon[35:16]});
                        check("wr_data", {16'd0, dq[i]}, {16'd0, e_mon[15:0]});
                    end
                    check("wr_strobes", {27'd0, dq_oe[i], ce_n[i], oe_n[i], lb_n[i], ub_n[i]}, 32'b10100);
                end
            end else if (lo[i] != 0) begin
                check("we_low_cycles", lo[i], 1);
                lo[i] = 0;
            end
        end
    end

    task automatic pulse(input int k);
        if (k == 0) start = 1'b1;
        else if (k == 1) pause = 1'b1;
        else stop = 1'b1;
        if (k == 0) exp_ptr[sel] = 0;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input bit store, input int gap);
        rec_if.tdata  = d;
        rec_if.tvalid = 1'b1;
        if (store) begin
            sb_push(sel, {20'(exp_ptr[sel]), d});
            exp_ptr[sel]++;
        end
        @(negedge clk);
        rec_if.tvalid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy[sel]}, 0);
    endtask

    task automatic check_reset_vals(input int i);
        check("rst_addr", {12'd0, addr[i]}, 0);
        check("rst_dq", {16'd0, dq[i]}, 0);
        check("rst_strobes", {26'd0, dq_oe[i], we_n[i], ce_n[i], oe_n[i], lb_n[i], ub_n[i]}, 32'b011111);
        check("rst_status", {28'd0, busy[i], paused[i], full[i], ovr[i]}, 0);
        check("rst_end_sec", {4'd0, end_addr[i], secs[i]}, 0);
    endtask

    initial begin
        rec_if.tdata  = '0;
        rec_if.tvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) check_reset_vals(i);

        // Basic recording of four samples
        sel = 0;
        pulse(0);
        check("busy_rec", {31'd0, busy[0]}, 1);
        send(16'h1234, 1, 31);
        send(16'hABCD, 1, 31);
        send(16'h0001, 1, 31);
        send(16'hFFFF, 1, 31);
        pulse(2);
        wait_idle("t1_idle");
        check("t1_end", {12'd0, end_addr[0]}, 4);
        check("t1_sb", sb_size(0), 0);

        // Paused samples are skipped
        pulse(0);
        for (int k = 0; k < 3; k++) send(16'h2000 + 16'(k), 1, 31);
        pulse(1);
        check("t2_paused", {31'd0, paused[0]}, 1);
        for (int k = 0; k < 5; k++) send(16'h3000 + 16'(k), 0, 31);
        pulse(1);
        check("t2_resumed", {31'd0, paused[0]}, 0);
        for (int k = 0; k < 2; k++) send(16'h4000 + 16'(k), 1, 31);
        pulse(2);
        wait_idle("t2_idle");
        check("t2_end", {12'd0, end_addr[0]}, 5);
        check("t2_ovr", {31'd0, ovr[0]}, 0);
        check("t2_sb", sb_size(0), 0);

        // Second sample lands on the hold cycle of the first write, third finds the register full
        pulse(0);
        send(16'hAAAA, 1, 3);
        send(16'hBBBB, 1, 0);
        send(16'hCCCC, 0, 30);
        check("t3_ovr_set", {31'd0, ovr[0]}, 1);
        pulse(2);
        wait_idle("t3_idle");
        check("t3_end", {12'd0, end_addr[0]}, 2);
        check("t3_sb", sb_size(0), 0);
        pulse(0);
        check("t3_ovr_clr", {31'd0, ovr[0]}, 0);
        pulse(2);
        wait_idle("t3_idle2");

        // Memory exhaustion with MAX_ADDR = 7
        sel = 1;
        pulse(0);
        for (int k = 0; k < 10; k++) send(16'h5000 + 16'(k), k < 8, 31);
        check("t4_full", {31'd0, full[1]}, 1);
        check("t4_busy", {31'd0, busy[1]}, 0);
        check("t4_end", {12'd0, end_addr[1]}, 8);
        check("t4_ovr", {31'd0, ovr[1]}, 0);
        check("t4_sb", sb_size(1), 0);

        // Seconds counter with SAMPLES_PER_SEC = 4
        sel = 2;
        pulse(0);
        for (int k = 0; k < 3; k++) send(16'h6000 + 16'(k), 1, 31);
        check("t5_sec_3", {24'd0, secs[2]}, 0);
        send(16'h6003, 1, 31);
        check("t5_sec_4", {24'd0, secs[2]}, 1);
        for (int k = 4; k < 9; k++) send(16'h6000 + 16'(k), 1, 31);
        check("t5_sec_9", {24'd0, secs[2]}, 2);
        pulse(2);
        wait_idle("t5_idle");
        pulse(0);
        check("t5_sec_clr", {24'd0, secs[2]}, 0);
        pulse(2);
        wait_idle("t5_idle2");
        check("t5_sb", sb_size(2), 0);

        // Asynchronous reset in the middle of a write strobe
        sel = 0;
        pulse(0);
        send(16'h5A5A, 1, 2);
        check("t6_in_strobe", {31'd0, we_n[0]}, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_we_oe", {30'd0, we_n[0], dq_oe[0]}, 32'b10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals(0);
        pulse(0);
        send(16'hC3C3, 1, 10);
        pulse(2);
        wait_idle("t6_idle");
        check("t6_end", {12'd0, end_addr[0]}, 1);
        check("t6_sb", sb_size(0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
